test_src_gen: RTL and testbench
===============================

Name: test_src_gen

Overview:
- Parametrised multi-channel test-pattern source; successor to the fixed 16-bit free-running counter sources that drive the sample-stream input of the AXI-to-stream bridge in test builds.
- Generates NCH packed channels of W-bit samples in one of four modes, with a valid/ready handshake, frame sync marking and runtime reconfiguration.
- Sits between the sample-clock domain logic and the bridge's Sin/Ien input.

Parameters:
- W, 16, sample width per channel (4..32).
- NCH, 2, channel count (1..8).
- FRAME_LEN, 1024, samples per frame; sync marks sample 0 (2..65536).
- LFSR_TAPS, 16'hB400, Galois feedback mask for PRBS mode; width W, zero-extended or truncated.

Ports:
- clk  in  1  sample clock.
- rst_n  in  1  synchronous reset, active low.
- en  in  1  generator enable.
- cfg_load  in  1  single-cycle pulse; latch mode, step and seed, and restart.
- mode  in  2  0 = counter, 1 = stepped counter, 2 = PRBS, 3 = constant.
- step  in  W  increment for mode 1.
- seed  in  W  start value (modes 0, 1, 2) or constant (mode 3).
- out_valid  out  1  dout is valid.
- out_ready  in  1  consumer accepts.
- dout  out  NCH*W  channel c occupies bits [c*W +: W].
- sync  out  1  qualifies the beat that is sample 0 of a frame.
- frame_cnt  out  16  completed frames, wraps modulo 2^16.

Behaviour:
- Handshake and reset
  - fire = out_valid && out_ready.
  - Reset (rst_n = 0 at a clk edge) gives: out_valid = 0, dout = 0, sync = 0, frame_cnt = 0, sample index = 0, mode_r = 0, step_r = 1, seed_r = 0.
  - Reset overrides everything, including mid-transfer; a stalled beat is dropped.
- Configuration
  - cfg_load is sampled at an edge. It latches mode, step and seed into mode_r, step_r and seed_r, clears the sample index and frame_cnt, and forces out_valid = 0 for the next cycle.
  - The first beat after the load carries the seed-derived value with sync = 1.
  - cfg_load beats en and fire in the same cycle; the stalled beat is discarded, not completed.
- Valid timing
  - en sampled 1 with out_valid = 0 → out_valid = 1 the next cycle. Latency from en to the first valid is 1 cycle.
  - en dropped while valid and not ready: the beat stays until fire (data stable, AXI-style), then out_valid = 0.
  - en = 0 with no beat pending: out_valid = 0 next cycle.
- Advance and stall
  - The generator advances only on fire. While out_valid && !out_ready, dout and sync hold exactly.
  - On fire with en = 1, the next beat is presented the following cycle, so back-to-back throughput is 1 beat per cycle.
- Per-channel values (v_c is the value for channel c, n is the beat index since the last load or reset, all arithmetic modulo 2^W)
  - Mode 0: v_c = seed_r + n + c.
  - Mode 1: v_c = seed_r + n*step_r + c. Implement as an accumulator adding step_r per fire.
  - Mode 2: independent Galois LFSR per channel.
    - Initial state seed_r ^ c.
    - An all-zero initial state is replaced by 1.
    - Each fire: next = (s >> 1) ^ (s[0] ? LFSR_TAPS : 0).
  - Mode 3: v_c = seed_r for all channels, for every beat.
- Frame counting
  - The sample index counts fires from 0 to FRAME_LEN-1 and then wraps to 0.
  - sync = 1 exactly on beats with index 0.
  - frame_cnt increments on the fire of index FRAME_LEN-1.
- Other rules
  - A mode change without cfg_load has no effect.
  - NCH = 1 is legal; c = 0 only.

Decomposition:
- Shared package test_src_pkg holds:
  - mode encoding constants MODE_CNT, MODE_STEP, MODE_PRBS, MODE_CONST;
  - the default LFSR_TAPS value;
  - FRAME_CNT_W = 16.
- Sub-module test_src_lane (one per channel, generate loop) holds the per-channel value register and the mode-dependent next-state logic. Its inputs are load, advance, mode_r, step_r and seed_r ^ c (or seed_r + c in counting modes).
- The top holds the handshake, the sample index, frame_cnt and sync.

Test Plan:
1. Reset, then cfg_load with mode = 0, seed = 0x0100, NCH = 2, en = 1, ready = 1 → first valid beat one cycle after the load's blank cycle:
   - ch0 = 0x0100, ch1 = 0x0101, sync = 1;
   - next beats 0x0101/0x0102, 0x0102/0x0103 with sync = 0.
2. Mode 1, step = 0x7FFF, seed = 0xFFFE, W = 16 → ch0 sequence 0xFFFE, 0x7FFD, 0xFFFC, which checks wrap-around.
3. Mode 0, ready held low for 5 cycles mid-stream → dout and sync stable for all 5 cycles; the sequence resumes with no skipped or duplicated value.
4. FRAME_LEN = 4, continuous ready → sync on beats 0, 4, 8; frame_cnt = 1 after beat 3 fires and 2 after beat 7.
5. Mode 2, seed = 0 → ch0 starts at 0x0001, ch1 starts at 0x0001. Check 20 beats against the reference LFSR model; no all-zero state appears.
6. Each of these mid-stall cases:
   - cfg_load while valid && !ready → out_valid = 0 for one cycle, then the new seed beat with sync = 1;
   - rst_n = 0 while valid && !ready → all outputs are at their reset values on the next cycle.

Source files
------------

// File: rtl/test_src_pkg.sv
// Shared definitions for the multi-channel test-pattern source.
package test_src_pkg;

  // Generator modes as seen on the mode input and held in the mode register.
  typedef enum logic [1:0] {
    MODE_CNT   = 2'd0,
    MODE_STEP  = 2'd1,
    MODE_PRBS  = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  // Default Galois feedback mask; lanes keep only the low W bits.
  localparam logic [31:0] LFSR_TAPS_DEF = 32'h0000_B400;

  // Width of the completed-frame counter.
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/test_src_lane.sv
// One channel of the test-pattern source: holds the value of the next beat
// to be presented and computes its successor for the active mode.
module test_src_lane
  import test_src_pkg::*;
#(
  parameter int          W    = 16,
  parameter int          C    = 0,
  parameter logic [31:0] TAPS = LFSR_TAPS_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_adv,
  input  mode_e        i_mode,
  input  logic [W-1:0] i_step,
  input  logic [W-1:0] i_seed,
  output logic [W-1:0] o_val
);

  localparam logic [W-1:0] W_C    = W'(C);
  localparam logic [W-1:0] W_ONE  = W'(1);
  localparam logic [W-1:0] W_TAPS = TAPS[W-1:0];

  logic [W-1:0] r_val;
  logic [W-1:0] w_cnt_init;
  logic [W-1:0] w_prbs_init;
  logic [W-1:0] w_init;
  logic [W-1:0] w_next;

  // One Galois LFSR step: shift right, fold the mask in when bit 0 falls out.
  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
    logic [W-1:0] fb;
    if (s[0]) begin
      fb = W_TAPS;
    end else begin
      fb = '0;
    end
    return (s >> 1) ^ fb;
  endfunction

  assign w_cnt_init  = i_seed + W_C;
  assign w_prbs_init = i_seed ^ W_C;

  // Select the start value and the per-beat successor for the current mode.
  always_comb begin
    w_init = w_cnt_init;
    w_next = r_val;
    case (i_mode)
      MODE_CNT: begin
        w_init = w_cnt_init;
        w_next = r_val + W_ONE;
      end
      MODE_STEP: begin
        w_init = w_cnt_init;
        w_next = r_val + i_step;
      end
      MODE_PRBS: begin
        // An all-zero LFSR would lock up, so it starts from 1 instead.
        if (w_prbs_init == '0) begin
          w_init = W_ONE;
        end else begin
          w_init = w_prbs_init;
        end
        w_next = lfsr_next(r_val);
      end
      MODE_CONST: begin
        w_init = i_seed;
        w_next = r_val;
      end
      default: begin
        w_init = w_cnt_init;
        w_next = r_val;
      end
    endcase
  end

  // Value register: reset to the mode-0/seed-0 start value, reload on config, step when a beat is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_val <= W_C;
    end else if (i_load) begin
      r_val <= w_init;
    end else if (i_adv) begin
      r_val <= w_next;
    end
  end

  assign o_val = r_val;

endmodule

// File: rtl/test_src_gen.sv
// Multi-channel test-pattern source with valid/ready output, frame sync and
// runtime reconfiguration. Lanes produce values; this level owns the handshake.
module test_src_gen
  import test_src_pkg::*;
#(
  parameter int          W         = 16,
  parameter int          NCH       = 2,
  parameter int          FRAME_LEN = 1024,
  parameter logic [31:0] LFSR_TAPS = LFSR_TAPS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   cfg_load,
  input  logic [1:0]             mode,
  input  logic [W-1:0]           step,
  input  logic [W-1:0]           seed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCH*W-1:0]       dout,
  output logic                   sync,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int                IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_LEN - 1);

  logic                   r_valid;
  logic [NCH*W-1:0]       r_dout;
  logic                   r_sync;
  logic                   r_last;
  logic [IDX_W-1:0]       r_idx;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  mode_e                  r_mode;
  logic [W-1:0]           r_step;
  logic [W-1:0]           r_seed;

  logic                   w_fire;
  logic                   w_take;
  mode_e                  w_mode;
  logic [W-1:0]           w_seed;
  logic [NCH*W-1:0]       w_lane_val;

  // Handshake decode; lanes see the incoming config on a load cycle so their start value is ready for the next beat.
  always_comb begin
    w_fire = r_valid && out_ready;
    // A new beat is presented when enabled and the output slot is free or being emptied.
    w_take = en && (!r_valid || w_fire) && !cfg_load;
    if (cfg_load) begin
      w_mode = mode_e'(mode);
      w_seed = seed;
    end else begin
      w_mode = r_mode;
      w_seed = r_seed;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    test_src_lane #(
      .W    (W),
      .C    (c),
      .TAPS (LFSR_TAPS)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (cfg_load),
      .i_adv  (w_take),
      .i_mode (w_mode),
      .i_step (r_step),
      .i_seed (w_seed),
      .o_val  (w_lane_val[c*W +: W])
    );
  end

  // Output beat, sample index, frame counter and latched configuration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_dout      <= '0;
      r_sync      <= 1'b0;
      r_last      <= 1'b0;
      r_idx       <= '0;
      r_frame_cnt <= '0;
      r_mode      <= MODE_CNT;
      r_step      <= W'(1);
      r_seed      <= '0;
    end else if (cfg_load) begin
      // Any pending beat is dropped; the next beat restarts the frame.
      r_mode      <= mode_e'(mode);
      r_step      <= step;
      r_seed      <= seed;
      r_valid     <= 1'b0;
      r_sync      <= 1'b0;
      r_last      <= 1'b0;
      r_idx       <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_fire && r_last) begin
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
      end
      if (w_take) begin
        r_valid <= 1'b1;
        r_dout  <= w_lane_val;
        r_sync  <= (r_idx == '0);
        r_last  <= (r_idx == IDX_LAST);
        if (r_idx == IDX_LAST) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end else if (w_fire) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign dout      = r_dout;
  assign sync      = r_sync;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_test_src_gen.sv
// Self-checking bench for test_src_gen (W=16, NCH=2, FRAME_LEN=4).
module tb_test_src_gen;

  localparam int W   = 16;
  localparam int NCH = 2;
  localparam int FL  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             cfg_load;
  logic [1:0]       mode;
  logic [W-1:0]     step;
  logic [W-1:0]     seed;
  logic             out_valid;
  logic             out_ready;
  logic [NCH*W-1:0] dout;
  logic             sync;
  logic [15:0]      frame_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] step;
    logic [15:0] seed;
    int          k;
    logic [15:0] e0;
    logic [15:0] e1;
    logic        es;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  test_src_gen #(
    .W         (W),
    .NCH       (NCH),
    .FRAME_LEN (FL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_load  (cfg_load),
    .mode      (mode),
    .step      (step),
    .seed      (seed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .sync      (sync),
    .frame_cnt (frame_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse cfg_load for one edge and check the blank cycle that follows.
  task automatic load(input logic [1:0] m, input logic [15:0] st, input logic [15:0] sd);
    mode     = m;
    step     = st;
    seed     = sd;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("blank_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic beat(input string name, input logic [15:0] e0, input logic [15:0] e1, input logic es);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_dout"}, dout, {e1, e0});
    chk({name, "_sync"}, {31'd0, sync}, {31'd0, es});
  endtask

  function automatic logic [15:0] lf(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  initial begin
    logic [15:0] m0;
    logic [15:0] m1;

    // mode, step, seed, beat, ch0, ch1, sync
    vecs[0]  = '{2'd0, 16'h0001, 16'h0100, 0, 16'h0100, 16'h0101, 1'b1};
    vecs[1]  = '{2'd0, 16'h0001, 16'h0100, 1, 16'h0101, 16'h0102, 1'b0};
    vecs[2]  = '{2'd0, 16'h0001, 16'h0100, 2, 16'h0102, 16'h0103, 1'b0};
    vecs[3]  = '{2'd1, 16'h7FFF, 16'hFFFE, 0, 16'hFFFE, 16'hFFFF, 1'b1};
    vecs[4]  = '{2'd1, 16'h7FFF, 16'hFFFE, 1, 16'h7FFD, 16'h7FFE, 1'b0};
    vecs[5]  = '{2'd1, 16'h7FFF, 16'hFFFE, 2, 16'hFFFC, 16'hFFFD, 1'b0};
    vecs[6]  = '{2'd3, 16'h0005, 16'hA5A5, 0, 16'hA5A5, 16'hA5A5, 1'b1};
    vecs[7]  = '{2'd3, 16'h0005, 16'hA5A5, 1, 16'hA5A5, 16'hA5A5, 1'b0};
    vecs[8]  = '{2'd3, 16'h0005, 16'hA5A5, 2, 16'hA5A5, 16'hA5A5, 1'b0};
    vecs[9]  = '{2'd2, 16'h0000, 16'h0000, 0, 16'h0001, 16'h0001, 1'b1};
    vecs[10] = '{2'd2, 16'h0000, 16'h0000, 1, 16'hB400, 16'hB400, 1'b0};
    vecs[11] = '{2'd2, 16'h0000, 16'h0000, 2, 16'h5A00, 16'h5A00, 1'b0};
    vecs[12] = '{2'd2, 16'h0000, 16'h0003, 0, 16'h0003, 16'h0002, 1'b1};
    vecs[13] = '{2'd2, 16'h0000, 16'h0003, 1, 16'hB401, 16'h0001, 1'b0};
    vecs[14] = '{2'd2, 16'h0000, 16'h0003, 2, 16'hEE00, 16'hB400, 1'b0};
    vecs[15] = '{2'd1, 16'h0010, 16'h1000, 0, 16'h1000, 16'h1001, 1'b1};
    vecs[16] = '{2'd1, 16'h0010, 16'h1000, 1, 16'h1010, 16'h1011, 1'b0};
    vecs[17] = '{2'd1, 16'h0010, 16'h1000, 2, 16'h1020, 16'h1021, 1'b0};

    // Reset state
    rst_n = 1'b0; en = 1'b0; cfg_load = 1'b0; out_ready = 1'b0;
    mode = 2'd0; step = 16'h0000; seed = 16'h0000;
    tick();
    tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_sync", {31'd0, sync}, 32'd0);
    chk("rst_fcnt", {16'd0, frame_cnt}, 32'd0);

    // Out of reset without a load: mode 0, seed 0, one cycle latency from en
    rst_n = 1'b1; en = 1'b1; out_ready = 1'b1;
    tick();
    beat("post_rst", 16'h0000, 16'h0001, 1'b1);

    // Table-driven configurations, continuous ready
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].k == 0) begin
        load(vecs[i].mode, vecs[i].step, vecs[i].seed);
      end
      tick();
      beat($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].es);
    end

    // Stall mid-stream for 5 cycles; a mode/seed change without load is ignored
    load(2'd0, 16'h0001, 16'h0200);
    tick();
    beat("stl_b0", 16'h0200, 16'h0201, 1'b1);
    tick();
    beat("stl_b1", 16'h0201, 16'h0202, 1'b0);
    out_ready = 1'b0;
    mode = 2'd3; seed = 16'hFFFF;
    for (int s = 0; s < 5; s++) begin
      tick();
      beat($sformatf("stl_hold%0d", s), 16'h0201, 16'h0202, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    beat("stl_b2", 16'h0202, 16'h0203, 1'b0);
    tick();
    beat("stl_b3", 16'h0203, 16'h0204, 1'b0);

    // Frame sync and frame counter with FRAME_LEN = 4
    load(2'd0, 16'h0001, 16'h0000);
    tick();
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("frm%0d_ch0", k), {16'd0, dout[15:0]}, k);
      chk($sformatf("frm%0d_sync", k), {31'd0, sync}, {31'd0, (k % 4) == 0});
      chk($sformatf("frm%0d_fcnt", k), {16'd0, frame_cnt}, k / 4);
      tick();
    end

    // PRBS from seed 0 against the reference LFSR, 20 beats
    load(2'd2, 16'h0000, 16'h0000);
    tick();
    m0 = 16'h0001;
    m1 = 16'h0001;
    for (int k = 0; k < 20; k++) begin
      beat($sformatf("prbs%0d", k), m0, m1, (k % 4) == 0);
      chk($sformatf("prbs%0d_nz", k), {31'd0, (dout[15:0] != 16'h0000) && (dout[31:16] != 16'h0000)}, 32'd1);
      m0 = lf(m0);
      m1 = lf(m1);
      tick();
    end

    // cfg_load while a beat is stalled: beat dropped, blank cycle, new seed beat
    out_ready = 1'b0;
    tick();
    mode = 2'd0; step = 16'h0001; seed = 16'h0300; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("ld_stall_valid", {31'd0, out_valid}, 32'd0);
    chk("ld_stall_fcnt", {16'd0, frame_cnt}, 32'd0);
    out_ready = 1'b1;
    tick();
    beat("ld_stall_b0", 16'h0300, 16'h0301, 1'b1);

    // Reset while a beat is stalled with a nonzero frame count
    for (int k = 0; k < 5; k++) tick();
    chk("pre_rst_fcnt", {16'd0, frame_cnt}, 32'd1);
    out_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_dout", dout, 32'd0);
    chk("mid_rst_sync", {31'd0, sync}, 32'd0);
    chk("mid_rst_fcnt", {16'd0, frame_cnt}, 32'd0);
    rst_n = 1'b1;
    en = 1'b0;
    tick();
    chk("idle_valid", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
